// File: rtl/sport_pkg.sv
// Shared encodings for the SPORT companding-expand scheduler.
package sport_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] DT_PASS = 2'b00;
  localparam logic [1:0] DT_MU   = 2'b10;
  localparam logic [1:0] DT_A    = 2'b11;

endpackage

// File: rtl/sport_exp_sched_if.sv
// Requester, expand-unit and response signals of the expand scheduler.
interface sport_exp_sched_if #(parameter int NREQ = 3);

  logic [NREQ-1:0]    req_v;
  logic [16*NREQ-1:0] req_d;
  logic [2*NREQ-1:0]  req_dt;
  logic [NREQ-1:0]    req_ack;
  logic [15:0]        du_rx;
  logic [1:0]         du_dt;
  logic [15:0]        du_exp;
  logic               rsp_v;
  logic [15:0]        rsp_d;
  logic [2:0]         rsp_id;
  logic               rsp_rdy;

  modport master (
    output req_v, req_d, req_dt, du_exp, rsp_rdy,
    input  req_ack, du_rx, du_dt, rsp_v, rsp_d, rsp_id
  );

  modport slave (
    input  req_v, req_d, req_dt, du_exp, rsp_rdy,
    output req_ack, du_rx, du_dt, rsp_v, rsp_d, rsp_id
  );

endinterface

// File: rtl/sport_exp_sched_arb.sv
// Combinational arbiter: round-robin from a pointer, or fixed lowest-index priority.
module exp_rr_arb #(
  parameter int NREQ = 3,
  parameter int RR   = 1
) (
  input  logic [NREQ-1:0] req_v,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      idx
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  always_comb begin
    int c;
    logic [IW-1:0] ci;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    // Candidates are visited in priority order; the pointer is always < NREQ so one wrap suffices.
    for (int k = 0; k < NREQ; k++) begin
      c = (RR != 0) ? int'(ptr) + k : k;
      if (c >= NREQ) c = c - NREQ;
      ci = IW'(c);
      if (!found && req_v[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = 3'(c);
      end
    end
  end

endmodule

// File: rtl/sport_exp_sched.sv
// Time-shares one combinational expand unit between NREQ requesters,
// holding its inputs for SETTLE cycles before capturing the result.
module sport_exp_sched
  import sport_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int RR     = 1,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  sport_exp_sched_if.slave bus,
  output logic             busy
);

  state_t          state, state_nx;
  logic [NREQ-1:0] gnt;
  logic [2:0]      gidx;
  logic [2:0]      ptr;
  logic [2:0]      id;
  logic [2:0]      cnt;
  logic            any_req;
  logic [15:0]     sel_d;
  logic [1:0]      sel_dt;
  logic [15:0]     rx_q;
  logic [1:0]      dt_q;
  logic            rsp_v_q;
  logic [15:0]     rsp_d_q;
  logic [2:0]      rsp_id_q;

  exp_rr_arb #(.NREQ(NREQ), .RR(RR)) u_arb (
    .req_v (bus.req_v),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gidx)
  );

  assign any_req = |bus.req_v;

  always_comb begin
    sel_d  = '0;
    sel_dt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_d  = bus.req_d[16*i +: 16];
        sel_dt = bus.req_dt[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any_req)      state_nx = S_WAIT;
      S_WAIT:  if (cnt == 3'd0)  state_nx = S_DONE;
      S_DONE:  if (bus.rsp_rdy)  state_nx = S_IDLE;
      default:                   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q     <= '0;
      dt_q     <= '0;
      id       <= '0;
      cnt      <= '0;
      ptr      <= '0;
      rsp_v_q  <= 1'b0;
      rsp_d_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            rx_q <= sel_d;
            dt_q <= sel_dt;
            id   <= gidx;
            cnt  <= 3'(SETTLE - 1);
            if (RR != 0) ptr <= (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            rsp_d_q  <= bus.du_exp;
            rsp_id_q <= id;
            rsp_v_q  <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DONE: if (bus.rsp_rdy) rsp_v_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Grants are combinational, so they are also gated by reset to keep every output low.
  assign bus.req_ack = (state == S_IDLE && !rst) ? gnt : '0;
  assign bus.du_rx   = rx_q;
  assign bus.du_dt   = dt_q;
  assign bus.rsp_v   = rsp_v_q;
  assign bus.rsp_d   = rsp_d_q;
  assign bus.rsp_id  = rsp_id_q;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_sport_exp_sched.sv
// Bench for sport_exp_sched: three instances (RR/SETTLE=1, fixed priority, SETTLE=4)
// each wrapped with a behavioural G.711 expand unit.
module tb_sport_exp_sched;

  logic clk;
  logic rst;
  logic busy_rr, busy_fp, busy_s4;
  int   checks;
  int   errors;

  sport_exp_sched_if #(.NREQ(3)) if_rr();
  sport_exp_sched_if #(.NREQ(3)) if_fp();
  sport_exp_sched_if #(.NREQ(3)) if_s4();

  sport_exp_sched #(.NREQ(3), .RR(1), .SETTLE(1)) u_rr (
    .clk(clk), .rst(rst), .bus(if_rr), .busy(busy_rr));
  sport_exp_sched #(.NREQ(3), .RR(0), .SETTLE(1)) u_fp (
    .clk(clk), .rst(rst), .bus(if_fp), .busy(busy_fp));
  sport_exp_sched #(.NREQ(3), .RR(1), .SETTLE(4)) u_s4 (
    .clk(clk), .rst(rst), .bus(if_s4), .busy(busy_s4));

  // Mu-law to 14-bit and A-law to 13-bit linear, sign-extended to 16 bits.
  function automatic logic [15:0] expand(input logic [15:0] d, input logic [1:0] dt);
    logic [7:0] c;
    logic [2:0] e;
    logic [3:0] m;
    int mag;
    int r;
    if (!dt[1]) return d;
    if (dt[0]) begin
      c = d[7:0] ^ 8'h55;
      e = c[6:4];
      m = c[3:0];
      if (e == 3'd0) mag = 2 * int'(m) + 1;
      else           mag = (2 * int'(m) + 33) << (int'(e) - 1);
      r = c[7] ? mag : -mag;
    end else begin
      c = ~d[7:0];
      e = c[6:4];
      m = c[3:0];
      mag = ((2 * int'(m) + 33) << int'(e)) - 33;
      r = c[7] ? -mag : mag;
    end
    return r[15:0];
  endfunction

  assign if_rr.du_exp = expand(if_rr.du_rx, if_rr.du_dt);
  assign if_fp.du_exp = expand(if_fp.du_rx, if_fp.du_dt);
  assign if_s4.du_exp = expand(if_s4.du_rx, if_s4.du_dt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] d;
    logic [1:0]  dt;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One isolated transaction on the round-robin instance with rsp_rdy high.
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    if_rr.req_v = '0;
    if_rr.req_v[v.idx] = 1'b1;
    if_rr.req_d = '0;
    if_rr.req_d[16*v.idx +: 16] = v.d;
    if_rr.req_dt = '0;
    if_rr.req_dt[2*v.idx +: 2] = v.dt;
    #1;
    check_output("vec_ack", 32'(if_rr.req_ack), 32'(1 << v.idx));
    @(negedge clk);
    if_rr.req_v = '0;
    #1;
    check_output("vec_wait_ack", 32'(if_rr.req_ack), 32'd0);
    check_output("vec_wait_busy", 32'(busy_rr), 32'd1);
    check_output("vec_wait_rsp_v", 32'(if_rr.rsp_v), 32'd0);
    check_output("vec_du_rx", 32'(if_rr.du_rx), 32'(v.d));
    check_output("vec_du_dt", 32'(if_rr.du_dt), 32'(v.dt));
    @(negedge clk);
    #1;
    check_output("vec_rsp_v", 32'(if_rr.rsp_v), 32'd1);
    check_output("vec_rsp_d", 32'(if_rr.rsp_d), 32'(v.exp_d));
    check_output("vec_rsp_id", 32'(if_rr.rsp_id), 32'(v.idx));
    @(negedge clk);
    #1;
    check_output("vec_idle_busy", 32'(busy_rr), 32'd0);
    check_output("vec_idle_rsp_v", 32'(if_rr.rsp_v), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if_rr.req_v = '0; if_rr.req_d = '0; if_rr.req_dt = '0; if_rr.rsp_rdy = 1'b1;
    if_fp.req_v = '0; if_fp.req_d = '0; if_fp.req_dt = '0; if_fp.rsp_rdy = 1'b1;
    if_s4.req_v = '0; if_s4.req_d = '0; if_s4.req_dt = '0; if_s4.rsp_rdy = 1'b1;

    vecs[0] = '{0, 16'h00FF, 2'b10, 16'h0000};
    vecs[1] = '{1, 16'h00D5, 2'b11, 16'h0001};
    vecs[2] = '{2, 16'h1234, 2'b00, 16'h1234};
    vecs[3] = '{0, 16'h0000, 2'b10, 16'hE0A1};
    vecs[4] = '{1, 16'h0055, 2'b11, 16'hFFFF};
    vecs[5] = '{2, 16'hABCD, 2'b00, 16'hABCD};

    repeat (2) @(negedge clk);
    #1;
    check_output("rst_busy", 32'(busy_rr), 32'd0);
    check_output("rst_rsp_v", 32'(if_rr.rsp_v), 32'd0);
    check_output("rst_rsp_d", 32'(if_rr.rsp_d), 32'd0);
    check_output("rst_rsp_id", 32'(if_rr.rsp_id), 32'd0);
    check_output("rst_du_rx", 32'(if_rr.du_rx), 32'd0);
    check_output("rst_du_dt", 32'(if_rr.du_dt), 32'd0);
    check_output("rst_ack", 32'(if_rr.req_ack), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Reset pulsed in the WAIT cycle discards the operation.
    @(negedge clk);
    if_rr.req_v = 3'b100;
    if_rr.req_d = {16'h5555, 32'h0};
    if_rr.req_dt = '0;
    #1;
    check_output("t1_ack", 32'(if_rr.req_ack), 32'h4);
    @(negedge clk);
    if_rr.req_v = '0;
    #1;
    check_output("t1_busy_wait", 32'(busy_rr), 32'd1);
    rst = 1'b1;
    #1;
    check_output("t1_rst_rsp_v", 32'(if_rr.rsp_v), 32'd0);
    check_output("t1_rst_busy", 32'(busy_rr), 32'd0);
    check_output("t1_rst_ack", 32'(if_rr.req_ack), 32'd0);
    check_output("t1_rst_du_rx", 32'(if_rr.du_rx), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_output("t1_no_rsp", 32'(if_rr.rsp_v), 32'd0);
      check_output("t1_idle", 32'(busy_rr), 32'd0);
    end

    // All requesters held high: RR rotates, fixed priority always picks 0.
    @(negedge clk);
    if_rr.req_v = 3'b111; if_rr.req_d = {16'h3333, 16'h2222, 16'h1111}; if_rr.req_dt = '0;
    if_fp.req_v = 3'b111; if_fp.req_d = {16'h3333, 16'h2222, 16'h1111}; if_fp.req_dt = '0;
    for (int c = 0; c < 18; c++) begin
      #1;
      check_output("t4_rr_ack", 32'(if_rr.req_ack), (c % 3 == 0) ? 32'(1 << ((c / 3) % 3)) : 32'd0);
      check_output("t4_fp_ack", 32'(if_fp.req_ack), (c % 3 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    if_rr.req_v = '0;
    if_fp.req_v = '0;
    #1;
    check_output("t4_rr_drain", 32'(if_rr.req_ack), 32'd0);

    // Backpressure in DONE with a competing request pending.
    @(negedge clk);
    if_rr.rsp_rdy = 1'b0;
    if_rr.req_v = 3'b010;
    if_rr.req_d = {16'h0000, 16'h0042, 16'h0777};
    if_rr.req_dt = '0;
    #1;
    check_output("t5_ack", 32'(if_rr.req_ack), 32'h2);
    @(negedge clk);
    if_rr.req_v = 3'b001;
    #1;
    check_output("t5_wait_ack", 32'(if_rr.req_ack), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_output("t5_hold_v", 32'(if_rr.rsp_v), 32'd1);
      check_output("t5_hold_d", 32'(if_rr.rsp_d), 32'h0042);
      check_output("t5_hold_id", 32'(if_rr.rsp_id), 32'd1);
      check_output("t5_hold_ack", 32'(if_rr.req_ack), 32'd0);
      @(negedge clk);
    end
    if_rr.rsp_rdy = 1'b1;
    #1;
    check_output("t5_hs_v", 32'(if_rr.rsp_v), 32'd1);
    @(negedge clk);
    #1;
    check_output("t5_idle_busy", 32'(busy_rr), 32'd0);
    check_output("t5_next_ack", 32'(if_rr.req_ack), 32'h1);
    @(negedge clk);
    if_rr.req_v = '0;
    #1;
    check_output("t5_wait2", 32'(busy_rr), 32'd1);
    @(negedge clk);
    #1;
    check_output("t5_rsp2_v", 32'(if_rr.rsp_v), 32'd1);
    check_output("t5_rsp2_d", 32'(if_rr.rsp_d), 32'h0777);
    check_output("t5_rsp2_id", 32'(if_rr.rsp_id), 32'd0);

    // SETTLE=4 latency and a request withdrawn before it is granted.
    @(negedge clk);
    if_s4.req_v = 3'b001;
    if_s4.req_d = {16'h0000, 16'h9999, 16'h00D5};
    if_s4.req_dt = {2'b00, 2'b00, 2'b11};
    #1;
    check_output("t6_ack", 32'(if_s4.req_ack), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) if_s4.req_v = 3'b010;
      if (k == 4) if_s4.req_v = '0;
      #1;
      check_output("t6_du_rx", 32'(if_s4.du_rx), 32'h00D5);
      check_output("t6_du_dt", 32'(if_s4.du_dt), 32'h3);
      check_output("t6_rsp_v_low", 32'(if_s4.rsp_v), 32'd0);
      check_output("t6_no_ack", 32'(if_s4.req_ack), 32'd0);
    end
    @(negedge clk);
    #1;
    check_output("t6_rsp_v", 32'(if_s4.rsp_v), 32'd1);
    check_output("t6_rsp_d", 32'(if_s4.rsp_d), 32'h0001);
    check_output("t6_rsp_id", 32'(if_s4.rsp_id), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check_output("t6_withdrawn_ack", 32'(if_s4.req_ack), 32'd0);
      check_output("t6_withdrawn_busy", 32'(busy_s4), 32'd0);
      check_output("t6_withdrawn_rsp", 32'(if_s4.rsp_v), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
